// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Registered bitwise logic unit. Each accepted transaction applies one of
//   eight bitwise operations to A and B. The result, its zero and parity flags
//   and the opcode are queued in a DEPTH-entry FIFO. The consumer reads the
//   FIFO head directly.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready operand-side handshake (push on in_valid && in_ready)
//   A, B, op          operands and opcode
//                     (0 AND, 1 NAND, 2 OR, 3 NOR, 4 NOT A, 5 XOR, 6 XNOR, 7 PASS A)
//   out_valid/out_ready result-side handshake (pop on out_valid && out_ready)
//   out_result, out_zero, out_parity, out_op   FIFO head contents
//   op_count          number of pops since reset (wraps)
// -----------------------------------------------------------------------------

// Combinational operation and flag generation for one transaction.
module logic_unit_op #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             parity_o
);
    always_comb begin
        res_o = '0;
        unique case (op_i)
            3'd0:    res_o = a_i & b_i;
            3'd1:    res_o = ~(a_i & b_i);
            3'd2:    res_o = a_i | b_i;
            3'd3:    res_o = ~(a_i | b_i);
            3'd4:    res_o = ~a_i;
            3'd5:    res_o = a_i ^ b_i;
            3'd6:    res_o = ~(a_i ^ b_i);
            default: res_o = a_i;
        endcase
    end

    assign zero_o   = (res_o == '0);
    assign parity_o = ^res_o;
endmodule

module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] op_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] res_mem_q [DEPTH];
    logic             zero_mem_q [DEPTH];
    logic             par_mem_q [DEPTH];
    logic [2:0]       op_mem_q [DEPTH];

    logic [WIDTH-1:0] res_c;
    logic             zero_c, par_c;
    logic             push, pop;

    logic_unit_op #(.WIDTH(WIDTH)) u_op (
        .a_i     (A),
        .b_i     (B),
        .op_i    (op),
        .res_o   (res_c),
        .zero_o  (zero_c),
        .parity_o(par_c)
    );

    // Ready depends only on the occupancy register, never on out_ready.
    assign in_ready  = (occ_q != OCC_W'(DEPTH));
    assign out_valid = (occ_q != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            occ_q <= occ_d;
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_mem_q[i]  <= '0;
                zero_mem_q[i] <= 1'b0;
                par_mem_q[i]  <= 1'b0;
                op_mem_q[i]   <= '0;
            end
        end else if (push) begin
            res_mem_q[wr_ptr_q]  <= res_c;
            zero_mem_q[wr_ptr_q] <= zero_c;
            par_mem_q[wr_ptr_q]  <= par_c;
            op_mem_q[wr_ptr_q]   <= op;
        end
    end

    assign out_result = res_mem_q[rd_ptr_q];
    assign out_zero   = zero_mem_q[rd_ptr_q];
    assign out_parity = par_mem_q[rd_ptr_q];
    assign out_op     = op_mem_q[rd_ptr_q];
    assign op_count   = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
  localparam int W = 8;
  localparam int D = 4;
  localparam int CW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [W-1:0] A = '0, B = '0, out_result;
  logic [2:0] op = '0, out_op;
  logic out_zero, out_parity;
  logic [CW-1:0] op_count;

  int checks = 0, errors = 0;

  logic_unit_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_parity(out_parity),
    .out_op(out_op), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] r; logic [2:0] o; } ent_t;
  ent_t q[$];
  int cnt = 0;

  function automatic logic [W-1:0] f(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] o);
    case (o)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return ~a;
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference FIFO model
  always @(negedge rst_n) begin
    q.delete();
    cnt = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit pu, po;
      ent_t e;
      pu = in_valid && (q.size() < D);
      po = (q.size() != 0) && out_ready;
      e.r = f(A, B, op);
      e.o = op;
      if (po) begin
        void'(q.pop_front());
        cnt = (cnt + 1) % (1 << CW);
      end
      if (pu) q.push_back(e);
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, q.size() != D);
      check("op_count", op_count, cnt);
      if (q.size() != 0) begin
        check("out_result", out_result, q[0].r);
        check("out_zero", out_zero, q[0].r == 0);
        check("out_parity", out_parity, ^q[0].r);
        check("out_op", out_op, q[0].o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in();
    A = W'($urandom);
    B = W'($urandom);
    op = 3'($urandom);
  endtask

  logic [W-1:0] exp_all [8] = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'h0F, 8'hCC, 8'h33, 8'hF0};
  logic [W-1:0] first;
  int c0;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_op", out_op, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Single op
    A = 8'hF0; B = 8'h3C; op = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    check("pre_push_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 8'h30);
    check("single_zero", out_zero, 0);
    check("single_parity", out_parity, 0);
    check("single_op", out_op, 0);
    tick();
    check("single_count", op_count, 1);
    check("single_empty", out_valid, 0);

    // All opcodes back-to-back
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      tick();
      check("allop_result", out_result, exp_all[i]);
      check("allop_zero", out_zero, 0);
      check("allop_parity", out_parity, 0);
      check("allop_op", out_op, i);
    end
    A = 8'h00; B = 8'h00; op = 3'd0;
    tick();
    check("zero_flag", out_zero, 1);
    in_valid = 1'b0;
    tick();

    // Fill and backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rnd_in();
      if (i == 0) first = f(A, B, op);
      tick();
      check("fill_in_ready", in_ready, i < 3);
      check("fill_head", out_result, first);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("drain_in_ready", in_ready, 1);
    repeat (3) tick();
    check("drained", out_valid, 0);

    // Simultaneous push/pop
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin rnd_in(); tick(); end
    out_ready = 1'b1;
    c0 = cnt;
    for (int i = 0; i < 6; i++) begin
      rnd_in();
      tick();
      check("pp_in_ready", in_ready, 1);
      check("pp_valid", out_valid, 1);
    end
    check("pp_count", op_count, (c0 + 6) % 16);
    in_valid = 1'b0;
    repeat (3) tick();

    // Async reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin rnd_in(); tick(); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_count", op_count, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    A = 8'h5A; B = 8'h0F; op = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_result", out_result, 8'h55);
    check("post_rst_op", out_op, 5);
    out_ready = 1'b1;
    tick();
    check("post_rst_count", op_count, 1);

    // Counter wrap: 17 pops with a 4-bit counter
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (17) begin rnd_in(); tick(); end
    in_valid = 1'b0;
    repeat (2) tick();
    check("wrap_count", op_count, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rnd_in();
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    check("final_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
